// File: rtl/mod_mult_serial_if.sv
// rtl/mod_mult_serial_if.sv - start/done handshake and operand bus of the serial modular multiplier
interface mod_mult_serial_if #(
    parameter int WIDTH = 256
);
    logic             i_start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] result;
    logic             o_done;
    logic             o_busy;

    modport master (
        output i_start, a, b, p,
        input  result, o_done, o_busy
    );

    modport slave (
        input  i_start, a, b, p,
        output result, o_done, o_busy
    );
endinterface

// File: rtl/mod_mult_serial.sv
// rtl/mod_mult_serial.sv - bit-serial interleaved (a*b) mod p, fixed latency; MODMUL_RADIX4_EN selects two bits per cycle
module mod_mult_serial #(
    parameter int WIDTH = 256
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    mod_mult_serial_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);
`ifdef MODMUL_RADIX4_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STEP - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH+1:0] acc_q;
    logic [WIDTH+1:0] acc_next;
    logic [CW-1:0]    cnt_q;
    logic             load;
    logic             last;

    // One interleaved step: double, reduce, conditionally add a, reduce.
    // With r < p every intermediate stays below 2p, so WIDTH+2 bits suffice.
    function automatic logic [WIDTH+1:0] mod_step(
        input logic [WIDTH+1:0] r,
        input logic             bit_v,
        input logic [WIDTH-1:0] av,
        input logic [WIDTH-1:0] pv
    );
        logic [WIDTH+1:0] t;
        logic [WIDTH+1:0] pw;
        pw = {2'b00, pv};
        t  = {r[WIDTH:0], 1'b0};
        if (t >= pw) t = t - pw;
        if (bit_v) begin
            t = t + {2'b00, av};
            if (t >= pw) t = t - pw;
        end
        return t;
    endfunction

    always_comb begin
        state_next = state;
        load       = 1'b0;
        last       = 1'b0;
`ifdef MODMUL_RADIX4_EN
        acc_next = mod_step(mod_step(acc_q, b_q[WIDTH-1], a_q, p_q), b_q[WIDTH-2], a_q, p_q);
`else
        acc_next = mod_step(acc_q, b_q[WIDTH-1], a_q, p_q);
`endif
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_LAST) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.i_start) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // b is shifted left so the bit under scan is always at the top.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                a_q   <= bus.a;
                b_q   <= bus.b;
                p_q   <= bus.p;
                acc_q <= '0;
                cnt_q <= CNT_INIT;
            end else if (state == BUSY) begin
                acc_q <= acc_next;
                b_q   <= b_q << STEP;
                cnt_q <= cnt_q - CW'(STEP);
                if (last) result_q <= acc_next[WIDTH-1:0];
            end
        end
    end

    assign bus.result = result_q;
    assign bus.o_done = (state == DONE);
    assign bus.o_busy = (state == BUSY);
endmodule

// File: tb/tb_mod_mult_serial.sv
// tb/tb_mod_mult_serial.sv - randomized self-checking bench for mod_mult_serial against an arithmetic reference
module tb_mod_mult_serial;
    localparam int W = 256;
`ifdef MODMUL_RADIX4_EN
    localparam int LAT = 128;
`else
    localparam int LAT = 256;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   st;
    logic [3:0]   done;
    logic [3:0]   busy;
    logic [W-1:0] av  [4];
    logic [W-1:0] bv  [4];
    logic [W-1:0] pv  [4];
    logic [W-1:0] res [4];

    int     n_chk = 0;
    int     n_pass = 0;
    int     busy_n;
    int     hold_bad;
    longint cyc_ctr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    mod_mult_serial_if #(.WIDTH(W)) bus [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_dut
        assign bus[g].i_start = st[g];
        assign bus[g].a       = av[g];
        assign bus[g].b       = bv[g];
        assign bus[g].p       = pv[g];
        assign res[g]         = bus[g].result;
        assign done[g]        = bus[g].o_done;
        assign busy[g]        = bus[g].o_busy;

        mod_mult_serial #(.WIDTH(W)) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .bus     (bus[g].slave)
        );
    end

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [W-1:0] m);
        logic [2*W-1:0] pr;
        pr = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        pr = pr % {{W{1'b0}}, m};
        return pr[W-1:0];
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom())};
        return r;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic start_op(input logic [3:0] mask);
        st = mask;
        @(posedge clk); #1;
        st = '0;
    endtask

    task automatic wait_done(input logic [3:0] mask, output int cyc);
        logic [W-1:0] r0;
        r0       = res[0];
        cyc      = 0;
        busy_n   = 0;
        hold_bad = 0;
        while ((done & mask) == 4'b0 && cyc < 1000) begin
            if (busy[0]) busy_n++;
            if (res[0] !== r0) hold_bad++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic single_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic [W-1:0] m);
        int cyc;
        av[0] = x; bv[0] = y; pv[0] = m;
        start_op(4'b0001);
        wait_done(4'b0001, cyc);
        check({tag, "_lat"}, W'(cyc), W'(LAT));
        check({tag, "_res"}, res[0], ref_mul(x, y, m));
    endtask

    logic [W-1:0] p25519;
    logic [W-1:0] p256;
    logic [W-1:0] m;
    int           cyc;
    int           cnt;
    longint       t1;

    initial begin
        rst_n = 1'b0;
        st    = '0;
        for (int i = 0; i < 4; i++) begin
            av[i] = '0; bv[i] = '0; pv[i] = '0;
        end
        p25519 = {1'b0, {255{1'b1}}} - W'(18);
        p256   = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;

        repeat (3) @(posedge clk);
        #1;
        check("rst_result", res[0], '0);
        check("rst_done", W'(done), '0);
        check("rst_busy", W'(busy), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", W'(busy), '0);

        // small operands: latency, busy window, done pulse width
        av[0] = W'(3); bv[0] = W'(5); pv[0] = W'(7);
        start_op(4'b0001);
        wait_done(4'b0001, cyc);
        check("basic_lat", W'(cyc), W'(LAT));
        check("basic_busy_cycles", W'(busy_n), W'(LAT));
        check("basic_busy_in_done", W'(busy[0]), '0);
        check("basic_res", res[0], W'(1));
        @(posedge clk); #1;
        check("basic_done_fall", W'(done[0]), '0);
        check("basic_res_hold", res[0], W'(1));

        single_op("p25519_max", p25519 - W'(1), p25519 - W'(1), p25519);
        check("p25519_max_one", res[0], W'(1));
        single_op("p25519_zero", '0, p25519 - W'(1), p25519);

        // start while busy must be ignored
        av[0] = W'(2); bv[0] = W'(3); pv[0] = W'(7);
        start_op(4'b0001);
        repeat (99) begin @(posedge clk); #1; end
        av[0] = W'(4); bv[0] = W'(4); st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        wait_done(4'b0001, cyc);
        check("ignore_lat", W'(cyc + 100), W'(LAT));
        check("ignore_res", res[0], W'(6));
        cnt = 0;
        repeat (300) begin @(posedge clk); #1; if (done[0]) cnt++; end
        check("ignore_no_second_done", W'(cnt), '0);

        // reset during BUSY aborts
        av[0] = W'(3); bv[0] = W'(4); pv[0] = W'(7);
        start_op(4'b0001);
        repeat (49) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", W'(busy[0]), '0);
        check("abort_done", W'(done[0]), '0);
        check("abort_res", res[0], '0);
        cnt = 0;
        repeat (LAT + 20) begin @(posedge clk); #1; if (done[0]) cnt++; end
        check("abort_no_done", W'(cnt), '0);
        single_op("after_abort", W'(3), W'(5), W'(7));

        // back-to-back with the second start in the DONE cycle
        av[0] = W'(5); bv[0] = W'(6); pv[0] = W'(11);
        start_op(4'b0001);
        wait_done(4'b0001, cyc);
        check("b2b_first_res", res[0], W'(8));
        t1 = cyc_ctr;
        av[0] = W'(10); bv[0] = W'(10);
        start_op(4'b0001);
        check("b2b_done_fall", W'(done[0]), '0);
        wait_done(4'b0001, cyc);
        check("b2b_spacing", W'(cyc_ctr - t1), W'(LAT + 1));
        check("b2b_hold", W'(hold_bad), '0);
        check("b2b_second_res", res[0], W'(1));

        // four parallel instances under P-256
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                pv[i] = p256;
                av[i] = rand_w() % p256;
                bv[i] = rand_w() % p256;
            end
            start_op(4'b1111);
            wait_done(4'b1111, cyc);
            check("par_lat", W'(cyc), W'(LAT));
            check("par_coincide", W'(done), W'(4'b1111));
            for (int i = 0; i < 4; i++) check("par_res", res[i], ref_mul(av[i], bv[i], pv[i]));
        end

        // random odd moduli
        for (int r = 0; r < 4; r++) begin
            m = rand_w() | W'(3);
            single_op("rand_mod", rand_w() % m, rand_w() % m, m);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
